adc_stream_packer: RTL and testbench

Parametrised successor to the single-channel ADC-to-AXI-stream path. It takes NUM_CH deserialised ADC channels, converts each sample to the selected output format and packs all channels into one AXI-stream beat. Output is framed into packets of programmable length with TLAST, buffered in a FIFO, and overflow drops are counted. It sits between the LVDS DDR capture stage and the AXI-stream master port; cfg_* inputs are driven from AXI-lite registers already synchronised to aclk.

---
 rtl/adc_stream_packer_if.sv | 25 ++
 rtl/adc_stream_packer.sv | 141 ++++++++++++++
 tb/tb_adc_stream_packer.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_stream_packer_if.sv
// Sample-input and AXI-stream output bundle of adc_stream_packer.
// master = the packer, slave = whatever feeds samples and sinks the stream.
`timescale 1ns/1ps
interface adc_stream_packer_if #(
    parameter int NUM_CH       = 2,
    parameter int DATA_WIDTH   = 14,
    parameter int SAMPLE_WIDTH = 16
);
    logic                           s_valid;
    logic [NUM_CH*DATA_WIDTH-1:0]   s_data;
    logic [NUM_CH*SAMPLE_WIDTH-1:0] m_axis_tdata;
    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic                           m_axis_tlast;

    modport master (
        input  s_valid, s_data, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output s_valid, s_data, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/adc_stream_packer.sv
// Packs NUM_CH ADC lanes per beat, frames packets with TLAST and buffers them
// in a first-word-fall-through FIFO, counting sample sets dropped on overflow.
`timescale 1ns/1ps
module adc_stream_packer #(
    parameter int NUM_CH        = 2,
    parameter int DATA_WIDTH    = 14,
    parameter int SAMPLE_WIDTH  = 16,
    parameter int FIFO_DEPTH    = 16,
    parameter int PKT_LEN_WIDTH = 16
) (
    input  logic                             aclk,
    input  logic                             reset,
    adc_stream_packer_if.master              io,
    input  logic                             cfg_enable,
    input  logic                             cfg_single,
    input  logic                             cfg_format,
    input  logic [PKT_LEN_WIDTH-1:0]         cfg_pkt_len,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic [15:0]                      overflow_cnt,
    output logic                             busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = NUM_CH * SAMPLE_WIDTH;

    typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_FLUSH} state_t;

    state_t                   r_state;
    logic [1:0]               r_rst_sync;
    logic                     w_rst;
    logic [PKT_LEN_WIDTH-1:0] r_len;
    logic [PKT_LEN_WIDTH-1:0] r_beat_cnt;
    logic                     r_single;
    logic                     r_rearm_wait;
    logic [15:0]              r_ovf_cnt;
    logic [BW:0]              r_mem [FIFO_DEPTH];
    logic [AW:0]              r_wr_ptr;
    logic [AW:0]              r_rd_ptr;
    logic [BW-1:0]            w_packed;
    logic [BW:0]              w_head;
    logic                     w_empty, w_full, w_pop, w_active, w_accept, w_reject, w_is_last;

    // Reset asserts immediately but is released on an aclk edge.
    always_ff @(posedge aclk or posedge reset) begin
        if (reset) r_rst_sync <= 2'b11;
        else       r_rst_sync <= {r_rst_sync[0], 1'b0};
    end
    assign w_rst = r_rst_sync[1];

    function automatic logic [SAMPLE_WIDTH-1:0] fmt_sample(
        input logic [DATA_WIDTH-1:0] raw,
        input logic                  twos
    );
        logic [DATA_WIDTH-1:0] t;
        t = raw;
        t[DATA_WIDTH-1] = raw[DATA_WIDTH-1] ^ twos;
        return twos ? SAMPLE_WIDTH'($signed(t)) : SAMPLE_WIDTH'(t);
    endfunction

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_packed = '0;
        for (int ch = 0; ch < NUM_CH; ch++)
            w_packed[ch*SAMPLE_WIDTH +: SAMPLE_WIDTH] =
                fmt_sample(io.s_data[ch*DATA_WIDTH +: DATA_WIDTH], cfg_format);
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && io.m_axis_tready;
    assign w_active  = (r_state != ST_IDLE);
    assign w_accept  = w_active && io.s_valid && (!w_full || w_pop);
    assign w_reject  = w_active && io.s_valid && !w_accept;
    assign w_is_last = (r_beat_cnt == r_len - PKT_LEN_WIDTH'(1));

    // NOTE: the storage array has no reset; only the pointers decide what is valid.
    always_ff @(posedge aclk) begin
        if (w_accept) r_mem[r_wr_ptr[AW-1:0]] <= {w_is_last, w_packed};
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge aclk or posedge w_rst) begin
        if (w_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    assign w_head           = r_mem[r_rd_ptr[AW-1:0]];
    assign io.m_axis_tvalid = !w_empty;
    assign io.m_axis_tdata  = w_empty ? '0 : w_head[BW-1:0];
    assign io.m_axis_tlast  = !w_empty && w_head[BW];
    assign fifo_level       = r_wr_ptr - r_rd_ptr;
    assign overflow_cnt     = r_ovf_cnt;
    assign busy             = (r_state != ST_IDLE);

    always_ff @(posedge aclk or posedge w_rst) begin
        if (w_rst) begin
            r_state      <= ST_IDLE;
            r_len        <= PKT_LEN_WIDTH'(1);
            r_beat_cnt   <= '0;
            r_single     <= 1'b0;
            r_rearm_wait <= 1'b0;
            r_ovf_cnt    <= '0;
        end else begin
            if (w_reject && r_ovf_cnt != 16'hFFFF) r_ovf_cnt <= r_ovf_cnt + 16'd1;
            if (w_accept) r_beat_cnt <= w_is_last ? '0 : r_beat_cnt + PKT_LEN_WIDTH'(1);

            case (r_state)
                ST_IDLE: begin
                    if (!cfg_enable) begin
                        r_rearm_wait <= 1'b0;
                    end else if (!r_rearm_wait) begin
                        r_state    <= ST_CAPTURE;
                        r_len      <= (cfg_pkt_len == '0) ? PKT_LEN_WIDTH'(1) : cfg_pkt_len;
                        r_beat_cnt <= '0;
                        r_single   <= cfg_single;
                    end
                end
                ST_CAPTURE: begin
                    if (w_accept && w_is_last && r_single) begin
                        r_state      <= ST_IDLE;
                        r_rearm_wait <= 1'b1;
                    end else if (!cfg_enable) begin
                        // Leave at once only if this cycle ends on a packet boundary.
                        if ((w_accept && w_is_last) || (!w_accept && r_beat_cnt == '0))
                            r_state <= ST_IDLE;
                        else
                            r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (w_accept && w_is_last) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_stream_packer.sv
// Self-checking bench for adc_stream_packer: format vectors, framing, overflow,
// disable/single-shot/reset sequences and a randomized run against a queue model.
`timescale 1ns/1ps
module tb_adc_stream_packer;
    localparam int NUM_CH = 2, DW = 14, SW = 16, DEPTH = 16, PLW = 16;

    logic            aclk = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_enable = 1'b0, cfg_single = 1'b0, cfg_format = 1'b0;
    logic [PLW-1:0]  cfg_pkt_len = '0;
    logic [4:0]      fifo_level;
    logic [15:0]     overflow_cnt;
    logic            busy;

    adc_stream_packer_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW)) bus ();

    adc_stream_packer #(
        .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW),
        .FIFO_DEPTH(DEPTH), .PKT_LEN_WIDTH(PLW)
    ) dut (
        .aclk         (aclk),
        .reset        (reset),
        .io           (bus),
        .cfg_enable   (cfg_enable),
        .cfg_single   (cfg_single),
        .cfg_format   (cfg_format),
        .cfg_pkt_len  (cfg_pkt_len),
        .fifo_level   (fifo_level),
        .overflow_cnt (overflow_cnt),
        .busy         (busy)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Offset-binary code minus mid-scale is the two's-complement value.
    function automatic logic [15:0] ref_lane(input int raw, input bit fmt);
        return fmt ? 16'(raw - 8192) : 16'(raw);
    endfunction

    function automatic logic [31:0] ref_beat(input int c0, input int c1, input bit fmt);
        return {ref_lane(c1, fmt), ref_lane(c0, fmt)};
    endfunction

    task automatic push(input int id);
        bus.s_valid = 1'b1;
        bus.s_data  = {14'(id + 100), 14'(id)};
        tick();
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cfg_enable = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_axis_tready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
    endtask

    typedef struct {
        logic [13:0] ch0;
        logic [13:0] ch1;
        logic        fmt;
        logic [31:0] exp;
    } fmt_vec_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } beat_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fmt_vec_t fv[5];
        beat_t    q[$];
        int nb, len, acc, ovf;

        fv[0] = '{14'h2000, 14'h1FFF, 1'b1, 32'hFFFF_0000};
        fv[1] = '{14'h2000, 14'h1FFF, 1'b0, 32'h1FFF_2000};
        fv[2] = '{14'h0000, 14'h3FFF, 1'b1, 32'h1FFF_E000};
        fv[3] = '{14'h3FFF, 14'h0000, 1'b0, 32'h0000_3FFF};
        fv[4] = '{14'h1234, 14'h2ABC, 1'b1, 32'h0ABC_F234};

        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_axis_tready = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_tvalid", bus.m_axis_tvalid, 0);
        check("rst_tdata",  bus.m_axis_tdata, 0);
        check("rst_tlast",  bus.m_axis_tlast, 0);
        check("rst_level",  fifo_level, 0);
        check("rst_ovf",    overflow_cnt, 0);
        check("rst_busy",   busy, 0);
        do_reset();

        // Format table; pkt_len 0 behaves as 1 so every beat carries tlast.
        cfg_pkt_len = 0;
        cfg_enable = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.s_data  = {fv[i].ch1, fv[i].ch0};
            cfg_format  = fv[i].fmt;
            bus.s_valid = 1'b1;
            tick();
            bus.s_valid = 1'b0;
            check("fmt_tvalid", bus.m_axis_tvalid, 1);
            check("fmt_tdata",  bus.m_axis_tdata, fv[i].exp);
            check("fmt_tlast",  bus.m_axis_tlast, 1);
            bus.m_axis_tready = 1'b1;
            tick();
            bus.m_axis_tready = 1'b0;
            check("fmt_level_after_pop", fifo_level, 0);
        end
        cfg_format = 1'b0;

        // Framing and latency, back-to-back with tready high.
        do_reset();
        cfg_pkt_len = 4;
        bus.m_axis_tready = 1'b1;
        cfg_enable = 1'b1;
        tick();
        nb = 0;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                bus.s_valid = 1'b1;
                bus.s_data  = {14'(k + 100), 14'(k)};
            end else begin
                bus.s_valid = 1'b0;
            end
            tick();
            if (k == 0) check("frame_first_latency", bus.m_axis_tvalid, 1);
            if (bus.m_axis_tvalid) begin
                check("frame_tdata", bus.m_axis_tdata, ref_beat(nb, nb + 100, 0));
                check("frame_tlast", bus.m_axis_tlast, (nb % 4) == 3);
                nb++;
            end
        end
        check("frame_beats", nb, 8);
        check("frame_ovf", overflow_cnt, 0);

        // Overflow with tready low, then push into a full FIFO while popping.
        do_reset();
        cfg_pkt_len = 4;
        cfg_enable = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) push(k);
        check("ovf_level", fifo_level, 16);
        check("ovf_count", overflow_cnt, 4);
        check("ovf_head",  bus.m_axis_tdata, ref_beat(0, 100, 0));
        bus.m_axis_tready = 1'b1;
        push(99);
        check("fullpop_level", fifo_level, 16);
        check("fullpop_ovf",   overflow_cnt, 4);
        for (int j = 1; j <= 16; j++) begin
            int id;
            id = (j < 16) ? j : 99;
            check("drain_tvalid", bus.m_axis_tvalid, 1);
            check("drain_tdata",  bus.m_axis_tdata, ref_beat(id, id + 100, 0));
            check("drain_tlast",  bus.m_axis_tlast, (j < 16) && (j % 4 == 3));
            tick();
        end
        check("drain_empty", bus.m_axis_tvalid, 0);
        check("drain_level", fifo_level, 0);

        // Disable after two beats: packet still completes, then IDLE.
        do_reset();
        cfg_pkt_len = 4;
        cfg_enable = 1'b1;
        tick();
        push(0);
        push(1);
        cfg_enable = 1'b0;
        push(2);
        check("dis_busy_flush", busy, 1);
        push(3);
        check("dis_busy_idle", busy, 0);
        push(4);
        check("dis_level", fifo_level, 4);
        check("dis_ovf",   overflow_cnt, 0);
        bus.m_axis_tready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("dis_tdata", bus.m_axis_tdata, ref_beat(j, j + 100, 0));
            check("dis_tlast", bus.m_axis_tlast, j == 3);
            tick();
        end
        check("dis_empty", bus.m_axis_tvalid, 0);

        // Single-shot: exactly one packet while enable stays high.
        do_reset();
        cfg_single = 1'b1;
        cfg_pkt_len = 3;
        bus.m_axis_tready = 1'b1;
        cfg_enable = 1'b1;
        tick();
        nb = 0;
        for (int k = 0; k < 8; k++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = {14'(k + 100), 14'(k)};
            tick();
            if (bus.m_axis_tvalid) begin
                check("single_tdata", bus.m_axis_tdata, ref_beat(nb, nb + 100, 0));
                check("single_tlast", bus.m_axis_tlast, nb == 2);
                nb++;
            end
        end
        bus.s_valid = 1'b0;
        tick();
        check("single_beats", nb, 3);
        check("single_busy",  busy, 0);
        check("single_level", fifo_level, 0);
        cfg_enable = 1'b0;
        tick();
        cfg_enable = 1'b1;
        tick();
        check("single_rearm", busy, 1);

        // Reset in the middle of a packet.
        cfg_enable = 1'b0;
        tick();
        cfg_single = 1'b0;
        cfg_pkt_len = 8;
        bus.m_axis_tready = 1'b0;
        cfg_enable = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) push(k);
        check("midrst_level_before", fifo_level, 5);
        cfg_pkt_len = 2;
        reset = 1'b1;
        #1;
        check("midrst_tvalid", bus.m_axis_tvalid, 0);
        check("midrst_level",  fifo_level, 0);
        check("midrst_busy",   busy, 0);
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        push(10);
        push(11);
        check("postrst_level", fifo_level, 2);
        check("postrst_tlast0", bus.m_axis_tlast, 0);
        bus.m_axis_tready = 1'b1;
        tick();
        check("postrst_tdata1", bus.m_axis_tdata, ref_beat(11, 111, 0));
        check("postrst_tlast1", bus.m_axis_tlast, 1);
        tick();
        bus.m_axis_tready = 1'b0;
        check("postrst_empty", bus.m_axis_tvalid, 0);

        // Randomized continuous capture against a packet-queue model.
        do_reset();
        len = $urandom_range(1, 5);
        cfg_pkt_len = PLW'(len);
        cfg_enable = 1'b1;
        tick();
        acc = 0;
        ovf = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int c0, c1;
            bit pop, accept;
            check("rnd_tvalid", bus.m_axis_tvalid, q.size() != 0);
            if (q.size() != 0) begin
                check("rnd_tdata", bus.m_axis_tdata, q[0].d);
                check("rnd_tlast", bus.m_axis_tlast, q[0].l);
            end
            check("rnd_level", fifo_level, q.size());
            check("rnd_ovf",   overflow_cnt, ovf);
            c0 = $urandom_range(0, 16383);
            c1 = $urandom_range(0, 16383);
            bus.s_valid = ($urandom_range(0, 9) < 7);
            bus.s_data  = {14'(c1), 14'(c0)};
            cfg_format  = 1'($urandom_range(0, 1));
            bus.m_axis_tready = (cyc < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            pop    = (q.size() != 0) && bus.m_axis_tready;
            accept = bus.s_valid && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (accept) begin
                q.push_back('{ref_beat(c0, c1, cfg_format), (acc % len) == len - 1});
                acc++;
            end else if (bus.s_valid) begin
                ovf++;
            end
            tick();
        end
        bus.s_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
